// File: rtl/axi4_scratchpad.sv
// rtl/axi4_scratchpad.sv - AXI4 slave backed by a single-port 32-bit word array, one burst at a time.
// Optional AXI4_SCRATCHPAD_ZEROINIT_EN adds a CLEAR sweep that zeroes every word after reset.
module axi4_scratchpad #(
    parameter int ADDR_BITS = 14,
    parameter int ID_BITS   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               bram_axi4_aw_valid,
    output logic               bram_axi4_aw_ready,
    input  logic [ID_BITS-1:0] bram_axi4_aw_id,
    input  logic [30:0]        bram_axi4_aw_addr,
    input  logic [7:0]         bram_axi4_aw_len,
    input  logic [2:0]         bram_axi4_aw_size,
    input  logic [1:0]         bram_axi4_aw_burst,
    input  logic               bram_axi4_w_valid,
    output logic               bram_axi4_w_ready,
    input  logic [31:0]        bram_axi4_w_data,
    input  logic [7:0]         bram_axi4_w_strb,
    input  logic               bram_axi4_w_last,
    output logic               bram_axi4_b_valid,
    input  logic               bram_axi4_b_ready,
    output logic [ID_BITS-1:0] bram_axi4_b_id,
    output logic [1:0]         bram_axi4_b_resp,
    input  logic               bram_axi4_ar_valid,
    output logic               bram_axi4_ar_ready,
    input  logic [ID_BITS-1:0] bram_axi4_ar_id,
    input  logic [30:0]        bram_axi4_ar_addr,
    input  logic [7:0]         bram_axi4_ar_len,
    input  logic [2:0]         bram_axi4_ar_size,
    input  logic [1:0]         bram_axi4_ar_burst,
    output logic               bram_axi4_r_valid,
    input  logic               bram_axi4_r_ready,
    output logic [ID_BITS-1:0] bram_axi4_r_id,
    output logic [31:0]        bram_axi4_r_data,
    output logic [1:0]         bram_axi4_r_resp,
    output logic               bram_axi4_r_last
);

    localparam int AW    = ADDR_BITS + 2;
    localparam int WORDS = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
        CLEAR = 3'd4,
`endif
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3
    } state_t;

    state_t               state, state_next;
    logic                 prio_write;
    logic [ID_BITS-1:0]   id_q;
    logic [AW-1:0]        addr_q;
    logic [7:0]           len_q, cnt_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic                 err_cfg, err_last;
    logic                 r_valid_q, r_last_q, issue_done;
    logic [31:0]          r_data_q;
    logic [31:0]          mem [WORDS];

    logic                 aw_ready_c, ar_ready_c, w_ready_c, b_valid_c;
    logic                 aw_hs, ar_hs, w_hs, r_hs, beat_last, rd_load;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_idx;
    logic [3:0]           mem_be;
    logic [31:0]          mem_wdata;
    logic                 unused_bits;

`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
    logic [ADDR_BITS-1:0] clr_idx;
`endif

    assign unused_bits = ^{bram_axi4_aw_addr[30:AW], bram_axi4_ar_addr[30:AW], bram_axi4_w_strb[7:4]};

    function automatic logic cfg_err(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    endfunction

    // WRAP keeps the bits above the (len+1)<<size window and wraps the rest.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] inc, mask;
        inc  = AW'(1) << size;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + inc) & mask);
            default: return a + inc;
        endcase
    endfunction

    assign beat_last = (cnt_q == len_q);
    assign aw_hs     = bram_axi4_aw_valid && aw_ready_c;
    assign ar_hs     = bram_axi4_ar_valid && ar_ready_c;
    assign w_hs      = bram_axi4_w_valid && w_ready_c;
    assign r_hs      = r_valid_q && bram_axi4_r_ready;
    assign rd_load   = (state == READ) && !issue_done && (!r_valid_q || bram_axi4_r_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        aw_ready_c = 1'b0;
        ar_ready_c = 1'b0;
        w_ready_c  = 1'b0;
        b_valid_c  = 1'b0;
        case (state)
`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
            CLEAR: if (clr_idx == '1) state_next = IDLE;
`endif
            IDLE: begin
                aw_ready_c = prio_write || !bram_axi4_ar_valid;
                ar_ready_c = !prio_write || !bram_axi4_aw_valid;
                if (bram_axi4_aw_valid && aw_ready_c)      state_next = WRITE;
                else if (bram_axi4_ar_valid && ar_ready_c) state_next = READ;
            end
            WRITE: begin
                w_ready_c = 1'b1;
                if (bram_axi4_w_valid && beat_last) state_next = WRESP;
            end
            WRESP: begin
                b_valid_c = 1'b1;
                if (bram_axi4_b_ready) state_next = IDLE;
            end
            READ: if (r_valid_q && bram_axi4_r_ready && r_last_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset) begin
            aw_ready_c = 1'b0;
            ar_ready_c = 1'b0;
            w_ready_c  = 1'b0;
            b_valid_c  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_write <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_cfg    <= 1'b0;
            err_last   <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            issue_done <= 1'b0;
`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
            clr_idx    <= '0;
`endif
        end else begin
            if (aw_hs) begin
                id_q    <= bram_axi4_aw_id;
                addr_q  <= bram_axi4_aw_addr[AW-1:0];
                len_q   <= bram_axi4_aw_len;
                size_q  <= bram_axi4_aw_size;
                burst_q <= bram_axi4_aw_burst;
                err_cfg <= cfg_err(bram_axi4_aw_len, bram_axi4_aw_size, bram_axi4_aw_burst);
            end else if (ar_hs) begin
                id_q    <= bram_axi4_ar_id;
                addr_q  <= bram_axi4_ar_addr[AW-1:0];
                len_q   <= bram_axi4_ar_len;
                size_q  <= bram_axi4_ar_size;
                burst_q <= bram_axi4_ar_burst;
                err_cfg <= cfg_err(bram_axi4_ar_len, bram_axi4_ar_size, bram_axi4_ar_burst);
            end
            if (aw_hs || ar_hs) begin
                cnt_q      <= '0;
                err_last   <= 1'b0;
                issue_done <= 1'b0;
                prio_write <= !prio_write;
            end
            if (w_hs) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
                if (bram_axi4_w_last != beat_last) err_last <= 1'b1;
            end
            // Output register doubles as the read pipeline stage; it only refills when drained.
            if (rd_load) begin
                r_valid_q <= 1'b1;
                r_last_q  <= beat_last;
                r_data_q  <= err_cfg ? '0 : mem[addr_q[AW-1:2]];
                cnt_q     <= cnt_q + 8'd1;
                addr_q    <= next_addr(addr_q, len_q, size_q, burst_q);
                if (beat_last) issue_done <= 1'b1;
            end else if (r_hs) begin
                r_valid_q <= 1'b0;
                r_last_q  <= 1'b0;
            end
`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
            if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
`endif
        end
    end

    always_comb begin
        mem_we    = w_hs && !err_cfg;
        mem_idx   = addr_q[AW-1:2];
        mem_be    = bram_axi4_w_strb[3:0];
        mem_wdata = bram_axi4_w_data;
`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_idx;
            mem_be    = 4'hF;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign bram_axi4_aw_ready = aw_ready_c;
    assign bram_axi4_ar_ready = ar_ready_c;
    assign bram_axi4_w_ready  = w_ready_c;
    assign bram_axi4_b_valid  = b_valid_c;
    assign bram_axi4_b_id     = reset ? '0 : id_q;
    assign bram_axi4_b_resp   = (reset || !(err_cfg || err_last)) ? 2'b00 : 2'b10;
    assign bram_axi4_r_valid  = r_valid_q && !reset;
    assign bram_axi4_r_id     = reset ? '0 : id_q;
    assign bram_axi4_r_data   = reset ? '0 : r_data_q;
    assign bram_axi4_r_resp   = (reset || !err_cfg) ? 2'b00 : 2'b10;
    assign bram_axi4_r_last   = r_last_q && !reset;

endmodule

// File: tb/tb_axi4_scratchpad.sv
// tb/tb_axi4_scratchpad.sv - directed self-checking bench for axi4_scratchpad.
module tb_axi4_scratchpad;
`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
    localparam int AB = 4;
`else
    localparam int AB = 14;
`endif
    localparam int IB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          aw_valid, aw_ready, ar_valid, ar_ready;
    logic [IB-1:0] aw_id, ar_id, b_id, r_id;
    logic [30:0]   aw_addr, ar_addr;
    logic [7:0]    aw_len, ar_len, w_strb;
    logic [2:0]    aw_size, ar_size;
    logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
    logic          w_valid, w_ready, w_last, b_valid, b_ready, r_valid, r_ready, r_last;
    logic [31:0]   w_data, r_data;

    int            checks = 0;
    int            failures = 0;
    logic [31:0]   wdat [16];
    logic [31:0]   rdat [16];
    logic          rlst [16];
    logic [1:0]    rrsp [16];
    logic [IB-1:0] rid [16];
    int            rcount, rlat, rspan, wbeats;
    logic [1:0]    bresp;
    logic [IB-1:0] bid;

    always #5 clock = ~clock;

    axi4_scratchpad #(.ADDR_BITS(AB), .ID_BITS(IB)) dut (
        .clock(clock), .reset(reset),
        .bram_axi4_aw_valid(aw_valid), .bram_axi4_aw_ready(aw_ready), .bram_axi4_aw_id(aw_id),
        .bram_axi4_aw_addr(aw_addr), .bram_axi4_aw_len(aw_len), .bram_axi4_aw_size(aw_size),
        .bram_axi4_aw_burst(aw_burst),
        .bram_axi4_w_valid(w_valid), .bram_axi4_w_ready(w_ready), .bram_axi4_w_data(w_data),
        .bram_axi4_w_strb(w_strb), .bram_axi4_w_last(w_last),
        .bram_axi4_b_valid(b_valid), .bram_axi4_b_ready(b_ready), .bram_axi4_b_id(b_id),
        .bram_axi4_b_resp(b_resp),
        .bram_axi4_ar_valid(ar_valid), .bram_axi4_ar_ready(ar_ready), .bram_axi4_ar_id(ar_id),
        .bram_axi4_ar_addr(ar_addr), .bram_axi4_ar_len(ar_len), .bram_axi4_ar_size(ar_size),
        .bram_axi4_ar_burst(ar_burst),
        .bram_axi4_r_valid(r_valid), .bram_axi4_r_ready(r_ready), .bram_axi4_r_id(r_id),
        .bram_axi4_r_data(r_data), .bram_axi4_r_resp(r_resp), .bram_axi4_r_last(r_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle;
        logic got;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            #1;
            got = aw_ready;
            if (!got) tick();
        end
        check("idle_after_reset", got, 1);
    endtask

    task automatic do_reset;
        reset = 1'b1; aw_valid = 1'b1; ar_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0; r_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", {aw_ready, ar_ready, w_ready}, 0);
        check("rst_valid", {b_valid, r_valid, r_last}, 0);
        check("rst_resp_id", {b_resp, r_resp, b_id, r_id}, 0);
        check("rst_rdata", r_data, 0);
        aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0;
        reset = 1'b0;
        wait_idle();
    endtask

    task automatic aw_do(input logic [IB-1:0] id, input logic [30:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        logic got;
        got = 1'b0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
        for (int t = 0; t < 60 && !got; t++) begin
            #1;
            got = aw_ready;
            tick();
        end
        aw_valid = 1'b0;
        check("aw_handshake", got, 1);
    endtask

    task automatic ar_do(input logic [IB-1:0] id, input logic [30:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        logic got;
        got = 1'b0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
        for (int t = 0; t < 60 && !got; t++) begin
            #1;
            got = ar_ready;
            tick();
        end
        ar_valid = 1'b0;
        check("ar_handshake", got, 1);
    endtask

    task automatic w_do(input int len, input logic [7:0] strb, input int last_at);
        logic got;
        wbeats = 0;
        for (int b = 0; b <= len; b++) begin
            w_data = wdat[b]; w_strb = strb; w_last = (b == last_at); w_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                #1;
                got = w_ready;
                tick();
            end
            if (got) wbeats++;
        end
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic b_do;
        logic got;
        got = 1'b0;
        b_ready = 1'b1;
        for (int t = 0; t < 30 && !got; t++) begin
            #1;
            got = b_valid;
            if (got) begin bresp = b_resp; bid = b_id; end
            tick();
        end
        b_ready = 1'b0;
        check("b_valid_seen", got, 1);
    endtask

    // Call right after ar_do; rlat counts cycles from the AR handshake to the first r_valid.
    task automatic r_do(input int pat);
        logic        done, stalled;
        logic [31:0] hd;
        logic [7:0]  hc;
        int          cyc, lastc;
        done = 1'b0; stalled = 1'b0; hd = '0; hc = '0;
        rcount = 0; rlat = 0; cyc = 1; lastc = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            r_ready = (pat == 0) ? 1'b1 : (((t % 4) == 0) || ((t % 4) == 3));
            #1;
            if (r_valid && rlat == 0) rlat = cyc;
            if (stalled) begin
                check("r_hold_data", r_data, hd);
                check("r_hold_ctl", {r_valid, r_last, r_resp, r_id}, hc);
            end
            if (r_valid && r_ready) begin
                if (rcount < 16) begin
                    rdat[rcount] = r_data; rlst[rcount] = r_last; rrsp[rcount] = r_resp; rid[rcount] = r_id;
                end
                rcount++;
                lastc = cyc;
                if (r_last) done = 1'b1;
            end
            stalled = r_valid && !r_ready;
            hd = r_data;
            hc = {r_valid, r_last, r_resp, r_id};
            tick();
            cyc++;
        end
        r_ready = 1'b0;
        rspan = lastc - rlat + 1;
        check("r_burst_done", done, 1);
    endtask

    task automatic r_expect(input string tag, input int n, input logic [1:0] resp, input logic [IB-1:0] id);
        check({tag, "_count"}, rcount, n);
        for (int i = 0; i < n && i < 16; i++) begin
            check({tag, "_data"}, rdat[i], wdat[i]);
            check({tag, "_last"}, rlst[i], (i == n - 1));
            check({tag, "_resp_id"}, {rrsp[i], rid[i]}, {resp, id});
        end
        check({tag, "_latency"}, rlat, 2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        do_reset();

        // INCR write 1..4 at words 4..7, then read back
        for (int i = 0; i < 4; i++) wdat[i] = i + 1;
        aw_do(4'h3, 31'h60010010, 8'd3, 3'd2, 2'b01);
        w_do(3, 8'h0F, 3);
        check("incr_w_beats", wbeats, 4);
        b_do();
        check("incr_b_resp", bresp, 2'b00);
        check("incr_b_id", bid, 4'h3);
        ar_do(4'h5, 31'h60010010, 8'd3, 3'd2, 2'b01);
        r_do(0);
        r_expect("incr_r", 4, 2'b00, 4'h5);
        check("incr_r_b2b", rspan, 4);

        // WRAP read starting at word 3 of a 16-byte window
        wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
        aw_do(4'h1, 31'h60010000, 8'd3, 3'd2, 2'b01);
        w_do(3, 8'h0F, 3);
        b_do();
        check("wrap_b_resp", bresp, 2'b00);
        ar_do(4'h2, 31'h6001000C, 8'd3, 3'd2, 2'b10);
        r_do(0);
        wdat[0] = 32'hD; wdat[1] = 32'hA; wdat[2] = 32'hB; wdat[3] = 32'hC;
        r_expect("wrap_r", 4, 2'b00, 4'h2);

        // size=3 write is rejected and leaves words 8..11 untouched
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        aw_do(4'h4, 31'h60010020, 8'd3, 3'd2, 2'b01);
        w_do(3, 8'h0F, 3);
        b_do();
        for (int i = 0; i < 4; i++) wdat[i] = 32'hFFFF_FFFF;
        aw_do(4'h6, 31'h60010020, 8'd3, 3'd3, 2'b01);
        w_do(3, 8'h0F, 3);
        check("size3_w_beats", wbeats, 4);
        b_do();
        check("size3_b_resp", bresp, 2'b10);
        check("size3_b_id", bid, 4'h6);
        ar_do(4'h7, 31'h60010020, 8'd3, 3'd2, 2'b01);
        r_do(0);
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        r_expect("size3_r", 4, 2'b00, 4'h7);

        // early w_last on beat 2 of 4: all four beats still taken, SLVERR
        for (int i = 0; i < 4; i++) wdat[i] = 32'h50 + i;
        aw_do(4'h8, 31'h60010030, 8'd3, 3'd2, 2'b01);
        w_do(3, 8'h0F, 1);
        check("wlast_w_beats", wbeats, 4);
        b_do();
        check("wlast_b_resp", bresp, 2'b10);

        // len=7 read with r_ready pattern 1,0,0,1
        wdat[0] = 1; wdat[1] = 2; wdat[2] = 3; wdat[3] = 4;
        wdat[4] = 32'h11; wdat[5] = 32'h22; wdat[6] = 32'h33; wdat[7] = 32'h44;
        ar_do(4'h9, 31'h60010010, 8'd7, 3'd2, 2'b01);
        r_do(1);
        r_expect("stall_r", 8, 2'b00, 4'h9);

        // byte strobes 0101 into word 5 (holding 2)
        wdat[0] = 32'hAABB_CCDD;
        aw_do(4'hA, 31'h60010014, 8'd0, 3'd2, 2'b01);
        w_do(0, 8'h05, 0);
        b_do();
        check("strb_b_resp", bresp, 2'b00);
        ar_do(4'hB, 31'h60010014, 8'd1, 3'd2, 2'b00);
        r_do(0);
        wdat[0] = 32'h00BB_00DD; wdat[1] = 32'h00BB_00DD;
        r_expect("fixed_r", 2, 2'b00, 4'hB);

        // burst=3 read: data zero, SLVERR, beat count honoured
        ar_do(4'hC, 31'h60010010, 8'd1, 3'd2, 2'b11);
        r_do(0);
        wdat[0] = 0; wdat[1] = 0;
        r_expect("burst3_r", 2, 2'b10, 4'hC);

        // round-robin arbitration from a fresh reset
        do_reset();
        aw_id = 4'h7; aw_addr = 31'h60010008; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b01;
        ar_id = 4'h9; ar_addr = 31'h60010008; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01;
        aw_valid = 1'b1; ar_valid = 1'b1;
        #1;
        check("arb1_ready", {aw_ready, ar_ready}, 2'b10);
        tick();
        aw_valid = 1'b0;
        wdat[0] = 32'h77;
        w_do(0, 8'h0F, 0);
        b_do();
        check("arb1_b_id", bid, 4'h7);
        aw_id = 4'h8; aw_valid = 1'b1;
        #1;
        check("arb2_ready", {aw_ready, ar_ready}, 2'b01);
        tick();
        ar_valid = 1'b0;
        r_do(0);
        r_expect("arb2_r", 1, 2'b00, 4'h9);
        ar_valid = 1'b1;
        #1;
        check("arb3_ready", {aw_ready, ar_ready}, 2'b10);
        tick();
        aw_valid = 1'b0; ar_valid = 1'b0;
        wdat[0] = 32'h88;
        w_do(0, 8'h0F, 0);
        b_do();
        check("arb3_b_id", bid, 4'h8);

`ifdef AXI4_SCRATCHPAD_ZEROINIT_EN
        begin
            int  lows;
            logic got;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            lows = 0;
            for (int i = 0; i < 8; i++) begin
                #1;
                if (!aw_ready) lows++;
                tick();
            end
            check("clr_first_half", lows, 8);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            lows = 0;
            got = 1'b0;
            for (int t = 0; t < 60 && !got; t++) begin
                #1;
                if (aw_ready) got = 1'b1;
                else begin lows++; tick(); end
            end
            check("clr_restart_len", lows, 16);
            ar_do(4'h1, 31'h60010000, 8'd15, 3'd2, 2'b01);
            r_do(0);
            for (int i = 0; i < 16; i++) wdat[i] = 0;
            r_expect("clr_r", 16, 2'b00, 4'h1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_scratchpad.md
AXI4_SCRATCHPAD -- requirements
Module: axi4_scratchpad

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 14, meaning word-address width (2^ADDR_BITS x 32-bit words, 64 kB at default).
REQ-002 SHALL have parameter ID_BITS, default 4, meaning width of AXI ID fields.
REQ-003 SHALL have one clock `clock` and reset `reset`; reset is synchronous and active-high.
REQ-004 SHALL have the following ports, listed as name / direction / width / meaning:
- clock / in / 1 / sole clock, rising edge.
- reset / in / 1 / synchronous active-high reset.
- bram_axi4_aw_{valid,ready,id,addr,len,size,burst} / in,out,in,in,in,in,in / 1,1,ID_BITS,31,8,3,2 / AXI4 write address.
- bram_axi4_w_{valid,ready,data,strb,last} / in,out,in,in,in / 1,1,32,8,1 / write data; only strb[3:0] used.
- bram_axi4_b_{valid,ready,id,resp} / out,in,out,out / 1,1,ID_BITS,2 / write response.
- bram_axi4_ar_{valid,ready,id,addr,len,size,burst} / in,out,in,in,in,in,in / same widths as aw / read address.
- bram_axi4_r_{valid,ready,id,data,resp,last} / out,in,out,out,out,out / 1,1,ID_BITS,32,2,1 / read data.

Function
REQ-005 SHALL use a single-port word array indexed by addr[ADDR_BITS+1:2]; upper address bits ignored (crossbar decodes).
REQ-006 SHALL implement FSM states CLEAR, IDLE, WRITE, WRESP, READ; one transaction in flight at a time.
REQ-007 In IDLE SHALL assert aw_ready/ar_ready per arbitration; handshake on a channel moves to WRITE or READ and latches id, addr, len, size, burst.
REQ-008 When aw_valid and ar_valid are both high in IDLE, SHALL grant round-robin: priority toggles after every granted transaction; after reset write has priority.
REQ-009 Beat address SHALL advance by 1<<size: FIXED (0) constant; INCR (1) linear; WRAP (2) wraps at boundary (len+1)<<size aligned; burst=3 treated as INCR with SLVERR.
REQ-010 size>2, burst=3, or WRAP with len not in {1,3,7,15} SHALL give resp SLVERR (2'b10); writes suppressed, read data zero; beat count still honoured.
REQ-011 WRITE: w_ready high; each accepted beat writes byte lanes where strb[i]=1 in the same cycle.
REQ-012 Burst SHALL end after exactly len+1 beats regardless of w_last; w_last mismatch on any beat forces SLVERR.
REQ-013 WRESP: b_valid high with latched id and resp until b_ready; then IDLE.
REQ-014 READ: first r_valid SHALL occur 2 cycles after AR handshake; with r_ready held high, beats SHALL be back-to-back.
REQ-015 r_valid low with r_ready SHALL hold r_data/r_id/r_resp/r_last stable; no beat may be lost or duplicated.
REQ-016 r_last SHALL be high only on beat len+1; after its handshake return to IDLE.
REQ-017 resp OKAY (2'b00) otherwise; EXOKAY never produced.
REQ-018 Read data SHALL reflect all writes completed (B handshake) before the AR handshake.

Reset
REQ-019 While reset is high at a clock edge: all valid/ready outputs 0; b_id, b_resp, r_id, r_data, r_resp, r_last 0; round-robin pointer to write.
REQ-020 Reset mid-transaction SHALL abandon it with no response; memory contents are retained except under REQ-022.

Configuration
REQ-021 Macro AXI4_SCRATCHPAD_ZEROINIT_EN SHALL select zero-initialisation.
REQ-022 Defined: after reset, enter CLEAR, write zero to one word per cycle for 2^ADDR_BITS cycles with all ready outputs low, then IDLE; reset during CLEAR restarts the sweep from word 0.
REQ-023 Undefined: CLEAR absent; reset goes directly to IDLE; contents are undefined until written.

Verification
REQ-024 INCR write, len=3, addr 0x60010010, data 1..4, strb 0xF, then INCR read len=3 -> r_data 1,2,3,4; r_last on beat 4; both resp OKAY.
REQ-025 WRAP read, len=3, size=2, addr 0x6001000C after words 0..3 hold A,B,C,D -> beats D,A,B,C.
REQ-026 aw_valid and ar_valid are asserted in the same cycle twice in a row -> the write is granted first, then the read, then the write again.
REQ-027 Write with size=3 -> b_resp 2'b10 and memory unchanged; w_last asserted on beat 2 of len=3 -> SLVERR, and 4 beats are still accepted.
REQ-028 Read len=7 with r_ready toggled 1,0,0,1 repeatedly -> all 8 beats appear in order, stable while stalled; a second bench checks that a read 2 cycles after AR returns data.
REQ-029 With AXI4_SCRATCHPAD_ZEROINIT_EN and ADDR_BITS=4, reset -> ready outputs low for 16 cycles, then any read returns 0; a reset pulse at cycle 8 restarts the 16-cycle sweep.
